crc_frame_ctrl: RTL and testbench

Sequencer for the serial 8-bit CRC LFSR. It accepts message bytes over a valid/ready handshake and clears the LFSR at frame start. It streams each byte LSB-first into the LFSR with ACTIVE high, then drops ACTIVE and collects the 8 serial CRC bits into a parallel result. It sits between the byte-oriented message source and the bit-serial LFSR, so the rest of the design never drives LFSR pins directly.

---
 rtl/crc_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_ctrl.sv
// rtl/crc_frame_ctrl.sv - byte-to-serial sequencer for a bit-serial CRC LFSR
// Feeds message bytes LSB-first into the LFSR, then gathers the serial CRC into a parallel word.
module crc_frame_ctrl #(
  parameter int CRC_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic             LFSR_RST,
  output logic             LFSR_ACTIVE,
  output logic             LFSR_DATA,
  input  logic             LFSR_CRC,
  input  logic             LFSR_VALID,
  output logic [CRC_W-1:0] CRC_OUT,
  output logic             CRC_DONE,
  output logic             ERR,
  output logic             BUSY
);

  localparam int CAP_W = (CRC_W > 1) ? $clog2(CRC_W) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         byte_q, byte_d;
  logic               last_q, last_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CRC_W-1:0]   shadow_q, shadow_d;

  logic               in_ready_q, in_ready_d;
  logic               lfsr_rst_q, lfsr_rst_d;
  logic               active_q, active_d;
  logic               data_q, data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [CRC_W-1:0]   crc_out_q;
  logic               crc_load;

  logic               hs;

  assign hs = IN_VALID & in_ready_q;

  // State register; outputs are registered from the next-state decode below.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      cap_q      <= '0;
      tmo_q      <= '0;
      shadow_q   <= '0;
      in_ready_q <= 1'b0;
      lfsr_rst_q <= 1'b0;
      active_q   <= 1'b0;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      crc_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      cap_q      <= cap_d;
      tmo_q      <= tmo_d;
      shadow_q   <= shadow_d;
      in_ready_q <= in_ready_d;
      lfsr_rst_q <= lfsr_rst_d;
      active_q   <= active_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      if (crc_load) begin
        crc_out_q <= shadow_d;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    last_d   = last_q;
    cap_d    = cap_q;
    tmo_d    = tmo_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          byte_d  = IN_DATA;
          last_d  = IN_LAST;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = 3'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (idx_q == 3'd7) begin
          if (last_q) begin
            cap_d    = '0;
            tmo_d    = '0;
            shadow_d = '0;
            state_d  = S_DRAIN;
          end else if (hs) begin
            // Next byte arrives on the final bit cycle so shifting continues without a gap.
            byte_d = IN_DATA;
            last_d = IN_LAST;
            idx_d  = 3'd0;
          end else begin
            state_d = S_ABORT;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_DRAIN: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (LFSR_VALID) begin
          shadow_d[cap_q] = LFSR_CRC;
          cap_d           = cap_q + CAP_W'(1);
        end
        // Completing the last capture on the final allowed cycle still counts as success.
        if (LFSR_VALID && (cap_q == CAP_W'(CRC_W - 1))) begin
          state_d = S_DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d = (state_d == S_IDLE) ||
                 ((state_d == S_SHIFT) && (idx_d == 3'd7) && !last_d);
    lfsr_rst_d = !((state_d == S_CLEAR) || (state_d == S_ABORT));
    active_d   = (state_d == S_SHIFT);
    data_d     = (state_d == S_SHIFT) ? byte_d[idx_d] : 1'b0;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ABORT);
    busy_d     = (state_d != S_IDLE);
    crc_load   = (state_q == S_DRAIN) && (state_d == S_DONE);
  end

  assign IN_READY    = in_ready_q;
  assign LFSR_RST    = lfsr_rst_q;
  assign LFSR_ACTIVE = active_q;
  assign LFSR_DATA   = data_q;
  assign CRC_OUT     = crc_out_q;
  assign CRC_DONE    = done_q;
  assign ERR         = err_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb/tb_crc_frame_ctrl.sv - directed and table-driven bench for crc_frame_ctrl
// Includes a behavioural LFSR stub (poly 0x07) that the frames drive through the DUT.
module tb_crc_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_LAST;
  logic       IN_READY;
  logic       LFSR_RST;
  logic       LFSR_ACTIVE;
  logic       LFSR_DATA;
  logic       LFSR_CRC;
  logic       LFSR_VALID;
  logic [7:0] CRC_OUT;
  logic       CRC_DONE;
  logic       ERR;
  logic       BUSY;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_k   = 0;

  logic [7:0] fb [0:1];
  logic       use_fixed;
  logic [7:0] fixed_val;
  logic [7:0] lf;
  logic [7:0] ob;

  typedef struct {
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [10];

  always #5 CLK = ~CLK;

  crc_frame_ctrl #(.CRC_W(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
    .LFSR_RST(LFSR_RST), .LFSR_ACTIVE(LFSR_ACTIVE), .LFSR_DATA(LFSR_DATA),
    .LFSR_CRC(LFSR_CRC), .LFSR_VALID(LFSR_VALID),
    .CRC_OUT(CRC_OUT), .CRC_DONE(CRC_DONE), .ERR(ERR), .BUSY(BUSY)
  );

  function automatic logic [7:0] step8(input logic [7:0] c, input logic d);
    logic f;
    f = c[7] ^ d;
    return {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc_of(input int n);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int j = 0; j < n; j++) begin
      b = fb[j];
      for (int i = 0; i < 8; i++) c = step8(c, b[i]);
    end
    return c;
  endfunction

  // LFSR stub: accumulates while ACTIVE, then shifts its value out LSB-first on VALID.
  always @(posedge CLK) begin
    if (!LFSR_RST) begin
      lf <= 8'h00;
      ob <= 8'h00;
    end else if (LFSR_ACTIVE) begin
      lf <= step8(lf, LFSR_DATA);
      ob <= use_fixed ? fixed_val : step8(lf, LFSR_DATA);
    end else if (LFSR_VALID) begin
      ob <= {1'b0, ob[7:1]};
    end
  end
  assign LFSR_CRC = ob[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle t+%0d): got %0h, expected %0h", name, cur_k, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, IN_READY, 0);
    chk({tag, "_lfsr_rst"}, LFSR_RST, 0);
    chk({tag, "_active"},   LFSR_ACTIVE, 0);
    chk({tag, "_data"},     LFSR_DATA, 0);
    chk({tag, "_crc_out"},  CRC_OUT, 0);
    chk({tag, "_done"},     CRC_DONE, 0);
    chk({tag, "_err"},      ERR, 0);
    chk({tag, "_busy"},     BUSY, 0);
  endtask

  // Runs one frame of n bytes from fb[]; vmode 0: VALID high, 1: toggling (low first), 2: low.
  task automatic frame(input int n, input bit under, input int vmode,
                       output int ev_k, output bit ev_err, output logic [7:0] ev_crc);
    int ds;
    int w;
    int b;
    int i;
    ds     = 2 + 8 * n;
    ev_k   = -1;
    ev_err = 1'b0;
    ev_crc = 8'h00;
    w      = 0;
    cur_k  = 0;
    while (!IN_READY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("ready_before_frame", IN_READY, 1);
    IN_VALID   = 1'b1;
    IN_DATA    = fb[0];
    IN_LAST    = (n == 1) && !under;
    LFSR_VALID = (vmode == 0);
    for (int k = 1; k <= 40 && ev_k < 0; k++) begin
      @(negedge CLK);
      cur_k    = k;
      IN_VALID = 1'b0;
      IN_DATA  = 8'($urandom);
      IN_LAST  = 1'($urandom);
      if (k == 1) begin
        chk("clear_lfsr_rst", LFSR_RST, 0);
        chk("clear_active", LFSR_ACTIVE, 0);
        chk("clear_busy", BUSY, 1);
        chk("clear_in_ready", IN_READY, 0);
      end else if (k < ds) begin
        b = (k - 2) / 8;
        i = (k - 2) % 8;
        chk("shift_active", LFSR_ACTIVE, 1);
        chk("shift_data", LFSR_DATA, fb[b][i]);
        chk("shift_lfsr_rst", LFSR_RST, 1);
        chk("shift_in_ready", IN_READY, (i == 7) && ((b < n - 1) || under));
        if (i == 7 && b < n - 1) begin
          IN_VALID = 1'b1;
          IN_DATA  = fb[b + 1];
          IN_LAST  = (b + 1 == n - 1);
        end
      end else if (CRC_DONE || ERR) begin
        ev_k   = k;
        ev_err = ERR;
        ev_crc = CRC_OUT;
        chk("done_err_exclusive", CRC_DONE & ERR, 0);
        if (ERR) chk("abort_lfsr_rst", LFSR_RST, 0);
      end else begin
        chk("drain_active", LFSR_ACTIVE, 0);
        chk("drain_data", LFSR_DATA, 0);
        chk("drain_in_ready", IN_READY, 0);
      end
      if (k >= ds) begin
        LFSR_VALID = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'((k - ds) % 2) : 1'b0;
      end else begin
        LFSR_VALID = (vmode == 0);
      end
    end
    if (ev_k < 0) chk("frame_event_timeout", 0, 1);
    @(negedge CLK);
    cur_k = cur_k + 1;
    chk("post_busy", BUSY, 0);
    chk("post_done", CRC_DONE, 0);
    chk("post_err", ERR, 0);
    chk("post_in_ready", IN_READY, 1);
  endtask

  initial begin
    int         k;
    bit         e;
    logic [7:0] c;
    logic [7:0] exp_a;

    RST        = 1'b1;
    IN_DATA    = 8'h00;
    IN_VALID   = 1'b0;
    IN_LAST    = 1'b0;
    LFSR_VALID = 1'b0;
    use_fixed  = 1'b0;
    fixed_val  = 8'h00;

    tbl[0].d = 8'h00; tbl[1].d = 8'hFF; tbl[2].d = 8'h01; tbl[3].d = 8'h80;
    tbl[4].d = 8'h5A; tbl[5].d = 8'hC3; tbl[6].d = 8'h7E; tbl[7].d = 8'h29;
    tbl[8].d = 8'hB4; tbl[9].d = 8'h6D;
    for (int j = 0; j < 10; j++) begin
      fb[0]      = tbl[j].d;
      tbl[j].exp = crc_of(1);
    end

    @(negedge CLK);
    @(negedge CLK);
    chk_reset("por");
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("por_release_in_ready", IN_READY, 1);
    chk("por_release_lfsr_rst", LFSR_RST, 1);

    // Single byte 0x96 with the stub forced to return 0xA5.
    use_fixed = 1'b1;
    fixed_val = 8'hA5;
    fb[0]     = 8'h96;
    frame(1, 1'b0, 0, k, e, c);
    chk("byte96_done_cycle", k, 18);
    chk("byte96_err", e, 0);
    chk("byte96_crc", c, 8'hA5);
    use_fixed = 1'b0;

    // Two-byte frame, second byte on the idx=7 cycle.
    fb[0] = 8'h12;
    fb[1] = 8'h34;
    exp_a = crc_of(2);
    frame(2, 1'b0, 0, k, e, c);
    chk("two_byte_done_cycle", k, 26);
    chk("two_byte_err", e, 0);
    chk("two_byte_crc", c, exp_a);

    // Underrun: non-last byte with no follower.
    fb[0] = 8'h55;
    frame(1, 1'b1, 0, k, e, c);
    chk("underrun_err_cycle", k, 10);
    chk("underrun_err", e, 1);
    chk("underrun_crc_kept", c, exp_a);

    // Drain with VALID every other cycle.
    fb[0] = 8'h3C;
    exp_a = crc_of(1);
    frame(1, 1'b0, 1, k, e, c);
    chk("gap_done_cycle", k, 26);
    chk("gap_err", e, 0);
    chk("gap_crc", c, exp_a);

    // Drain timeout with VALID stuck low.
    fb[0] = 8'hE1;
    frame(1, 1'b0, 2, k, e, c);
    chk("timeout_err_cycle", k, 26);
    chk("timeout_err", e, 1);
    chk("timeout_crc_kept", c, exp_a);

    for (int j = 0; j < 10; j++) begin
      fb[0] = tbl[j].d;
      frame(1, 1'b0, 0, k, e, c);
      chk($sformatf("tbl%0d_done_cycle", j), k, 18);
      chk($sformatf("tbl%0d_err", j), e, 0);
      chk($sformatf("tbl%0d_crc", j), c, tbl[j].exp);
    end

    // Reset mid-SHIFT with a byte offered during reset.
    fb[0] = 8'hA7;
    cur_k = 0;
    chk("rst_seq_ready", IN_READY, 1);
    IN_VALID = 1'b1;
    IN_DATA  = fb[0];
    IN_LAST  = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_seq_in_shift", LFSR_ACTIVE, 1);
    RST      = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h3F;
    @(negedge CLK);
    chk_reset("midrst1");
    @(negedge CLK);
    chk_reset("midrst2");
    RST      = 1'b0;
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("midrst_after_ready", IN_READY, 1);
    chk("midrst_after_busy", BUSY, 0);
    chk("midrst_after_done", CRC_DONE, 0);
    chk("midrst_after_err", ERR, 0);
    chk("midrst_after_crc", CRC_OUT, 0);
    @(negedge CLK);
    chk("midrst_no_accept", BUSY, 0);

    // Recovery frame after reset.
    fb[0] = 8'h96;
    exp_a = crc_of(1);
    frame(1, 1'b0, 0, k, e, c);
    chk("recover_done_cycle", k, 18);
    chk("recover_crc", c, exp_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
